lsu_bus_controller: RTL and testbench
=====================================

Name: lsu_bus_controller

Overview:
- Sequences every data-memory access issued from the MEM stage onto the req/gnt/rvalid data bus.
- Consumes the 3-bit width_src code, address and store data.
- Generates word-aligned bus address, byte enables and replicated write data, then stalls the pipeline until the response returns.
- Aligns and sign/zero-extends load data, and flags misaligned/illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in RESP waiting for bus_rvalid_i before bus_err_o (range 1..255)

Ports:
clk_i  input  1  clock, all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
mem_op_valid_i  input  1  MEM-stage instruction is a load or store
mem_write_i  input  1  1 = store, 0 = load
width_src_i  input  3  000 word, 001 byte, 010 half, 101 byte unsigned, 110 half unsigned; others illegal
addr_i  input  32  byte address
wdata_i  input  32  store data (low bits significant)
flush_i  input  1  squash current MEM-stage access
stall_o  output  1  hold pipeline
load_data_o  output  32  extended load result
load_valid_o  output  1  load_data_o valid this cycle
misalign_o  output  1  misaligned or illegal-width access (combinational)
bus_err_o  output  1  pulse: response timeout
bus_req_o  output  1  bus request
bus_we_o  output  1  bus write
bus_addr_o  output  32  {addr[31:2],2'b00}
bus_be_o  output  4  byte enables
bus_wdata_o  output  32  lane-replicated store data
bus_gnt_i  input  1  request accepted
bus_rvalid_i  input  1  response/ack valid (reads and writes)
bus_rdata_i  input  32  read data

Behaviour:
- Reset (reset_i=1 at an edge): state=IDLE, timeout counter=0, discard=0, load_data_o=0, every bus_* output 0, load_valid_o=0, bus_err_o=0. Applies mid-transaction; the in-flight access is abandoned and no response is tracked.
- States: IDLE, REQ, RESP, DONE.
- Fault: misalign_o = mem_op_valid_i & state==IDLE & (illegal code | half with addr[0] | word with addr[1:0]!=0). A faulting access issues no bus activity and does not stall.
- IDLE, valid non-faulting op with !flush_i:
  - Latch we, width, addr[1:0], be, wdata; go to REQ.
  - stall_o=1 in this cycle.
- REQ:
  - bus_req_o=1, with bus_addr/be/we/wdata driven from latched values and held stable until gnt.
  - gnt → RESP, counter cleared.
  - flush_i with !gnt → IDLE, no access.
  - flush_i with gnt → RESP with discard=1.
- RESP:
  - bus_req_o=0; counter increments each cycle.
  - flush_i sets discard.
  - rvalid → DONE. For a load, capture the extended bus_rdata_i into load_data_o; if discard is set, return to IDLE instead, with no load_valid_o and load_data_o unchanged.
  - Counter reaching TIMEOUT_CYCLES without rvalid → DONE with bus_err_o=1 for one cycle and load_data_o=0.
  - rvalid never precedes gnt; rvalid in the gnt cycle is ignored.
- DONE:
  - stall_o=0.
  - load_valid_o=1 if the access was a load.
  - Next state is IDLE unconditionally, so the next instruction is seen in IDLE.
- stall_o=1 in IDLE (launching op), REQ and RESP; 0 otherwise.
- Byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: 0001<<addr[1:0].
- Write data replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as is.
- Load alignment: shift rdata right by 8*addr[1:0], then:
  - 000: as is.
  - 001: sign-extend [7:0].
  - 010: sign-extend [15:0].
  - 101: zero-extend [7:0].
  - 110: zero-extend [15:0].
- load_data_o holds its value until the next completed load or reset.
- Minimum latency with gnt in REQ and rvalid next cycle: 3 stall cycles (IDLE, REQ, RESP), result in the 4th cycle (DONE).

Test Plan:
- Load: lb addr=0x1003, rdata=0x80FF_1234 → be=0001<<3=1000, bus_addr=0x1000, load_data_o=0xFFFFFF80. Then lbu at the same address → 0x00000080. Stall exactly 3 cycles with gnt and rvalid each on the first possible cycle.
- Store: sh addr=0x2002, wdata=0x0000ABCD → be=1100, bus_wdata=0xABCDABCD, bus_we=1, req held through 3 cycles of gnt=0, load_valid_o never 1.
- Faults: lw addr=0x3001 and width_src=011 → misalign_o=1, stall_o=0, bus_req_o never asserted.
- Timeout: TIMEOUT_CYCLES=4, rvalid withheld → bus_err_o pulses in DONE, load_data_o=0, then IDLE.
- Flush: flush_i in REQ before gnt → IDLE, no further req. Flush in RESP → on rvalid, return to IDLE with load_valid_o=0 and load_data_o unchanged.
- Reset: reset_i asserted during RESP → next cycle all outputs 0, state IDLE. A late rvalid then has no effect, and a new lw completes normally.

Source files
------------

// File: rtl/lsu_bus_controller.sv
// Load/store unit bus sequencer: drives MEM-stage accesses onto a req/gnt/rvalid
// data bus, stalls the pipeline until the response, and aligns/extends load data.
module lsu_bus_controller #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_op_valid_i,
    input  logic        mem_write_i,
    input  logic [2:0]  width_src_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        discard;
    logic        timed_out;
    logic [31:0] load_data;

    logic        we;
    logic [2:0]  width;
    logic [1:0]  offset;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [29:0] word_addr;

    logic        fault;
    logic        launch;
    logic        in_req;

    function automatic logic illegal_width(input logic [2:0] w);
        return !(w == 3'b000 || w == 3'b001 || w == 3'b010 ||
                 w == 3'b101 || w == 3'b110);
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] w, input logic [1:0] off);
        logic [3:0] r;
        case (w[1:0])
            2'b00:   r = 4'b1111;
            2'b01:   r = 4'b0001 << off;
            default: r = off[1] ? 4'b1100 : 4'b0011;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] w, input logic [31:0] d);
        logic [31:0] r;
        case (w[1:0])
            2'b01:   r = {4{d[7:0]}};
            2'b10:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] w, input logic [1:0] off,
                                                input logic [31:0] rd);
        logic        [31:0] sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        sh = rd >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (w)
            3'b001:  r = b;
            3'b010:  r = h;
            3'b101:  r = {24'd0, sh[7:0]};
            3'b110:  r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    assign fault = illegal_width(width_src_i) ||
                   (width_src_i[1:0] == 2'b10 && addr_i[0]) ||
                   (width_src_i == 3'b000 && addr_i[1:0] != 2'b00);

    assign launch     = mem_op_valid_i && state == IDLE && !fault && !flush_i;
    assign misalign_o = mem_op_valid_i && state == IDLE && fault;

    // Control path: state, response timer, discard and timeout tracking.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            discard   <= 1'b0;
            timed_out <= 1'b0;
            load_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    discard   <= 1'b0;
                    timed_out <= 1'b0;
                    if (launch) state <= REQ;
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        state   <= RESP;
                        cnt     <= 8'd0;
                        discard <= flush_i;
                    end else if (flush_i) begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    if (bus_rvalid_i) begin
                        // A squashed access still has to drain its response.
                        if (discard || flush_i) begin
                            state <= IDLE;
                        end else begin
                            state <= DONE;
                            if (!we) load_data <= extend_load(width, offset, bus_rdata_i);
                        end
                    end else if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        timed_out <= 1'b1;
                        load_data <= 32'd0;
                    end else begin
                        cnt     <= cnt + 8'd1;
                        discard <= discard || flush_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Access attributes captured at launch and held for the whole transaction.
    always_ff @(posedge clk_i) begin
        if (launch) begin
            we        <= mem_write_i;
            width     <= width_src_i;
            offset    <= addr_i[1:0];
            be        <= byte_enables(width_src_i, addr_i[1:0]);
            wdata     <= replicate(width_src_i, wdata_i);
            word_addr <= addr_i[31:2];
        end
    end

    assign in_req      = state == REQ;
    assign bus_req_o   = in_req;
    assign bus_we_o    = in_req && we;
    assign bus_addr_o  = in_req ? {word_addr, 2'b00} : 32'd0;
    assign bus_be_o    = in_req ? be : 4'd0;
    assign bus_wdata_o = in_req ? wdata : 32'd0;

    assign stall_o      = launch || state == REQ || state == RESP;
    assign load_valid_o = state == DONE && !we;
    assign bus_err_o    = state == DONE && timed_out;
    assign load_data_o  = load_data;

endmodule

// File: tb/tb_lsu_bus_controller.sv
// Directed self-checking bench for lsu_bus_controller: loads, stores, faults,
// flushes, mid-transaction reset and response timeout.
module tb_lsu_bus_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_op_valid;
    logic        mem_write;
    logic [2:0]  width_src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int          r_stalls, r_reqs;
    logic [31:0] r_addr, r_wdata, r_ld;
    logic [3:0]  r_be;
    logic        r_we, r_lv, r_err, r_changed, r_done;

    always #5 clk = ~clk;

    lsu_bus_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .mem_op_valid_i (mem_op_valid),
        .mem_write_i    (mem_write),
        .width_src_i    (width_src),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .flush_i        (flush),
        .stall_o        (stall_o),
        .load_data_o    (load_data_o),
        .load_valid_o   (load_valid_o),
        .misalign_o     (misalign_o),
        .bus_err_o      (bus_err_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_be_o       (bus_be_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_gnt_i      (bus_gnt),
        .bus_rvalid_i   (bus_rvalid),
        .bus_rdata_i    (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full access; gnt after gnt_wait refused request cycles, rvalid the cycle after gnt.
    task automatic access(input logic wr, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gnt_wait, input logic give_rv);
        logic rv_pend;
        logic first;
        rv_pend = 1'b0; first = 1'b1;
        r_stalls = 0; r_reqs = 0; r_done = 1'b0; r_changed = 1'b0;
        r_lv = 1'b0; r_err = 1'b0; r_ld = 32'd0;
        r_addr = 32'd0; r_be = 4'd0; r_wdata = 32'd0; r_we = 1'b0;
        mem_op_valid = 1'b1; mem_write = wr; width_src = w; addr = a; wdata = wd; flush = 1'b0;
        for (int c = 0; c < 40 && !r_done; c++) begin
            bus_gnt    = 1'b0;
            bus_rvalid = rv_pend;
            bus_rdata  = rv_pend ? rd : 32'h0;
            rv_pend    = 1'b0;
            #2;
            if (bus_req_o) begin
                if (first) begin
                    r_addr = bus_addr_o; r_be = bus_be_o; r_wdata = bus_wdata_o; r_we = bus_we_o;
                    first = 1'b0;
                end else if ({bus_addr_o, bus_be_o, bus_wdata_o, bus_we_o} !=
                             {r_addr, r_be, r_wdata, r_we}) begin
                    r_changed = 1'b1;
                end
                r_reqs++;
                if (r_reqs > gnt_wait) begin
                    bus_gnt = 1'b1;
                    rv_pend = give_rv;
                end
            end
            if (stall_o) begin
                r_stalls++;
            end else begin
                r_done = 1'b1;
                r_lv   = load_valid_o;
                r_ld   = load_data_o;
                r_err  = bus_err_o;
            end
            step();
        end
        mem_op_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        check("access_done", 32'(r_done), 32'd1);
    endtask

    task automatic fault_case(input string tag, input logic [2:0] w, input logic [31:0] a);
        logic seen;
        mem_op_valid = 1'b1; mem_write = 1'b0; width_src = w; addr = a;
        #2;
        check({tag, "_misalign"}, 32'(misalign_o), 32'd1);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            #2;
            seen = seen | bus_req_o;
        end
        check({tag, "_no_req"}, 32'(seen), 32'd0);
        mem_op_valid = 1'b0;
        step();
    endtask

    initial begin
        logic seen;
        reset = 1'b1; mem_op_valid = 1'b0; mem_write = 1'b0; width_src = 3'b000;
        addr = 32'd0; wdata = 32'd0; flush = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (2) step();
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_ld", load_data_o, 32'd0);
        check("rst_lv", 32'(load_valid_o), 32'd0);
        check("rst_err", 32'(bus_err_o), 32'd0);
        check("rst_be", 32'(bus_be_o), 32'd0);
        reset = 1'b0;
        step();

        access(1'b0, 3'b001, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 1'b1);
        check("lb_addr", r_addr, 32'h0000_1000);
        check("lb_be", 32'(r_be), 32'h8);
        check("lb_we", 32'(r_we), 32'd0);
        check("lb_data", r_ld, 32'hFFFF_FF80);
        check("lb_valid", 32'(r_lv), 32'd1);
        check("lb_stalls", r_stalls, 32'd3);
        check("lb_reqs", r_reqs, 32'd1);

        access(1'b0, 3'b101, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 1'b1);
        check("lbu_data", r_ld, 32'h0000_0080);
        check("lbu_stalls", r_stalls, 32'd3);

        access(1'b0, 3'b010, 32'h0000_1002, 32'd0, 32'h80FF_1234, 0, 1'b1);
        check("lh_be", 32'(r_be), 32'hC);
        check("lh_data", r_ld, 32'hFFFF_80FF);

        access(1'b0, 3'b110, 32'h0000_1000, 32'd0, 32'h80FF_F234, 0, 1'b1);
        check("lhu_be", 32'(r_be), 32'h3);
        check("lhu_data", r_ld, 32'h0000_F234);

        access(1'b0, 3'b000, 32'h0000_4000, 32'd0, 32'hDEAD_BEEF, 0, 1'b1);
        check("lw_be", 32'(r_be), 32'hF);
        check("lw_addr", r_addr, 32'h0000_4000);
        check("lw_data", r_ld, 32'hDEAD_BEEF);

        access(1'b1, 3'b010, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 3, 1'b1);
        check("sh_addr", r_addr, 32'h0000_2000);
        check("sh_be", 32'(r_be), 32'hC);
        check("sh_wdata", r_wdata, 32'hABCD_ABCD);
        check("sh_we", 32'(r_we), 32'd1);
        check("sh_reqs", r_reqs, 32'd4);
        check("sh_stable", 32'(r_changed), 32'd0);
        check("sh_valid", 32'(r_lv), 32'd0);
        check("sh_stalls", r_stalls, 32'd6);
        check("sh_ld_kept", r_ld, 32'hDEAD_BEEF);

        access(1'b1, 3'b001, 32'h0000_2001, 32'h1234_5678, 32'd0, 0, 1'b1);
        check("sb_be", 32'(r_be), 32'h2);
        check("sb_wdata", r_wdata, 32'h7878_7878);

        fault_case("lw_mis", 3'b000, 32'h0000_3001);
        fault_case("bad_w", 3'b011, 32'h0000_3000);
        fault_case("lh_mis", 3'b010, 32'h0000_1001);

        // Flush while waiting for grant.
        mem_op_valid = 1'b1; mem_write = 1'b0; width_src = 3'b000; addr = 32'h0000_6000;
        step();
        #2;
        check("flreq_req", 32'(bus_req_o), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0; mem_op_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            seen = seen | bus_req_o | stall_o | load_valid_o;
            step();
        end
        check("flreq_idle", 32'(seen), 32'd0);

        // Flush while waiting for response.
        mem_op_valid = 1'b1; mem_write = 1'b0; width_src = 3'b000; addr = 32'h0000_7000;
        step();
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0; flush = 1'b1; mem_op_valid = 1'b0;
        step();
        flush = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
        #2;
        check("flresp_stall", 32'(stall_o), 32'd1);
        step();
        bus_rvalid = 1'b0;
        #2;
        check("flresp_lv", 32'(load_valid_o), 32'd0);
        check("flresp_stall2", 32'(stall_o), 32'd0);
        check("flresp_ld", load_data_o, 32'hDEAD_BEEF);
        step();

        // Reset during RESP abandons the access.
        mem_op_valid = 1'b1; mem_write = 1'b0; width_src = 3'b000; addr = 32'h0000_8000;
        step();
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0; mem_op_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        #2;
        check("rstmid_stall", 32'(stall_o), 32'd0);
        check("rstmid_req", 32'(bus_req_o), 32'd0);
        check("rstmid_ld", load_data_o, 32'd0);
        check("rstmid_lv", 32'(load_valid_o), 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_rvalid = 1'b0;
        #2;
        check("late_rv_lv", 32'(load_valid_o), 32'd0);
        check("late_rv_ld", load_data_o, 32'd0);
        check("late_rv_stall", 32'(stall_o), 32'd0);
        step();
        access(1'b0, 3'b000, 32'h0000_8004, 32'd0, 32'h1357_2468, 0, 1'b1);
        check("post_rst_lw", r_ld, 32'h1357_2468);
        check("post_rst_lv", 32'(r_lv), 32'd1);

        // Response never arrives.
        access(1'b0, 3'b000, 32'h0000_5000, 32'd0, 32'd0, 0, 1'b0);
        check("to_err", 32'(r_err), 32'd1);
        check("to_ld", r_ld, 32'd0);
        check("to_stalls", r_stalls, 32'd6);
        #2;
        check("to_err_pulse", 32'(bus_err_o), 32'd0);
        check("to_idle", 32'(stall_o), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
